clk_divider_prog: RTL and testbench

Multi-channel programmable clock divider. It generates NUM_CH divided clocks from clk_i using registered outputs only, so each output is glitch-free and can drive local FF clock pins through LUT/FF fabric. It supports odd and even ratios, runtime ratio reload at period boundaries, and graceful per-channel stop. It supersedes the fixed divide-by-4 two-stage divider for clock-fabric benchmarks.

---
 rtl/clk_div_pkg.sv | 26 ++
 rtl/clk_div_chan.sv | 116 +++++++++++
 rtl/clk_divider_prog.sv | 44 ++++
 tb/tb_clk_divider_prog.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and ratio helpers for the programmable clock divider.
// Ratios below MIN_DIV are clamped inside hi_len/lo_len so callers never see D<2.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } div_state_e;

  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned clamp_div(input int unsigned d);
    return (d < MIN_DIV) ? MIN_DIV : d;
  endfunction

  // Odd ratios put the extra cycle in the high phase.
  function automatic int unsigned hi_len(input int unsigned d);
    return (clamp_div(d) + 1) / 2;
  endfunction

  function automatic int unsigned lo_len(input int unsigned d);
    return clamp_div(d) / 2;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: IDLE/HIGH/LOW FSM, phase counter and pending-ratio register.
// Optional tick_o (rise strobe) is present only when CLKDIV_TICK_EN is defined.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 4
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             en_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             load_i,
  output logic             load_ack_o,
  output logic             active_o,
  output logic             clk_o
`ifdef CLKDIV_TICK_EN
  ,
  output logic             tick_o
`endif
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0] pend_q;
  logic             pend_vld_q;
  logic             apply;
  logic             clk_q, ack_q;

  // A new ratio may only take effect where a fresh period starts.
  assign apply = ((state_q == IDLE) && en_i) ||
                 ((state_q == LOW) && (cnt_q == '0));
  assign ratio_d = (apply && pend_vld_q) ? pend_q : ratio_q;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = HIGH;
          cnt_d   = CNT_W'(hi_len(32'(ratio_d)) - 1);
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          state_d = LOW;
          cnt_d   = CNT_W'(lo_len(32'(ratio_q)) - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
          state_d = en_i ? HIGH : IDLE;
          cnt_d   = CNT_W'(hi_len(32'(ratio_d)) - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ratio_q <= CNT_W'(DIV_RST);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
    end
  end

  // A load coinciding with a boundary wins over the clear and waits for the next one.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      clk_q <= (state_d == HIGH);
      ack_q <= apply && pend_vld_q;
      if (load_i) begin
        pend_q     <= div_i;
        pend_vld_q <= 1'b1;
      end else if (apply) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

  assign clk_o      = clk_q;
  assign load_ack_o = ack_q;
  assign active_o   = (state_q != IDLE);

`ifdef CLKDIV_TICK_EN
  logic tick_q;

  always_ff @(posedge clk_i) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= (state_d == HIGH) && (state_q != HIGH);
  end

  assign tick_o = tick_q;
`else
  // Without the tick port the rise decode is not built.
`endif

endmodule

// File: rtl/clk_divider_prog.sv
// Multi-channel programmable clock divider with flop-driven, glitch-free outputs.
// Define CLKDIV_TICK_EN to add tick_o, a clk_i-domain strobe on every clk_o rise.
module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 4
) (
  input  logic                    clk_i,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH*CNT_W-1:0] div_i,
  input  logic [NUM_CH-1:0]       load_i,
  output logic [NUM_CH-1:0]       load_ack_o,
  output logic [NUM_CH-1:0]       active_o,
  output logic [NUM_CH-1:0]       clk_o
`ifdef CLKDIV_TICK_EN
  ,
  output logic [NUM_CH-1:0]       tick_o
`endif
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk_i      (clk_i),
      .rst        (rst),
      .en_i       (en_i[k]),
      .div_i      (div_i[k*CNT_W +: CNT_W]),
      .load_i     (load_i[k]),
      .load_ack_o (load_ack_o[k]),
      .active_o   (active_o[k]),
      .clk_o      (clk_o[k])
`ifdef CLKDIV_TICK_EN
      ,
      .tick_o     (tick_o[k])
`endif
    );
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Scoreboard bench for clk_divider_prog: each step queues the hand-written expected
// outputs for the next edge; a negedge monitor pops and compares them.
module tb_clk_divider_prog;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic                    clk_i = 1'b0;
  logic                    rst   = 1'b1;
  logic [NUM_CH-1:0]       en_i  = '0;
  logic [NUM_CH-1:0]       load_i = '0;
  logic [NUM_CH*CNT_W-1:0] div_i = '0;
  logic [NUM_CH-1:0]       load_ack_o, active_o, clk_o;
`ifdef CLKDIV_TICK_EN
  logic [NUM_CH-1:0]       tick_o;
`endif

  clk_divider_prog #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DIV_RST (4)
  ) dut (
    .clk_i      (clk_i),
    .rst        (rst),
    .en_i       (en_i),
    .div_i      (div_i),
    .load_i     (load_i),
    .load_ack_o (load_ack_o),
    .active_o   (active_o),
    .clk_o      (clk_o)
`ifdef CLKDIV_TICK_EN
    ,
    .tick_o     (tick_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string             name;
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] act;
    logic [NUM_CH-1:0] ack;
    logic [NUM_CH-1:0] tick;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              mon_e;
  int                n_tests = 0;
  int                n_fail  = 0;
  string             cur_name = "reset";
  logic [NUM_CH-1:0] prev_clk = '0;
  logic [NUM_CH-1:0] got_tick, want_tick;

  // Monitor: one expected vector per cycle, compared half a period after the edge.
  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
`ifdef CLKDIV_TICK_EN
      got_tick  = tick_o;
      want_tick = mon_e.tick;
`else
      got_tick  = '0;
      want_tick = '0;
`endif
      n_tests++;
      if ({clk_o, active_o, load_ack_o, got_tick} !==
          {mon_e.clk, mon_e.act, mon_e.ack, want_tick}) begin
        n_fail++;
        $display("FAIL %s @%0t: got clk=%b act=%b ack=%b tick=%b, want clk=%b act=%b ack=%b tick=%b",
                 mon_e.name, $time, clk_o, active_o, load_ack_o, got_tick,
                 mon_e.clk, mon_e.act, mon_e.ack, want_tick);
      end
    end
  end

  // Per-channel code: '-' idle, '0' low, '1' high, 'A' high with load ack.
  task automatic step(input byte c0, input byte c1);
    exp_t e;
    byte  cs[NUM_CH];
    cs[0] = c0;
    cs[1] = c1;
    e.name = cur_name;
    for (int k = 0; k < NUM_CH; k++) begin
      e.clk[k] = (cs[k] == "1") || (cs[k] == "A");
      e.act[k] = (cs[k] != "-");
      e.ack[k] = (cs[k] == "A");
    end
    e.tick   = e.clk & ~prev_clk;
    prev_clk = e.clk;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    load_i = '0;
  endtask

  task automatic run(input string name, input string p0, input string p1);
    cur_name = name;
    for (int i = 0; i < p0.len(); i++)
      step(p0[i], (p1.len() > i) ? p1[i] : 8'h2d);
  endtask

  task automatic load0(input logic [CNT_W-1:0] d);
    div_i[CNT_W-1:0] = d;
    load_i[0] = 1'b1;
  endtask

  initial begin
    run("reset", "---", "---");
    rst = 1'b0;

    // Reset ratio 4 on ch0, ch1 left off.
    en_i = 2'b01;
    run("div_rst4", "11001100", "--------");
    en_i = 2'b00;
    run("div_rst4_stop", "-", "-");

    // D=5 loaded while idle: ack on first high, 3 high / 2 low.
    load0(8'd5);
    run("d5_load_idle", "-", "-");
    en_i = 2'b01;
    run("d5_run", "A110011100", "");
    en_i = 2'b00;
    run("d5_stop", "-", "");

    // D=4 running, D=6 loaded mid-high: current period finishes 2/2, then 3/3.
    load0(8'd4);
    run("d4_load", "-", "");
    en_i = 2'b01;
    run("d4_first", "A", "");
    load0(8'd6);
    run("d4_mid_load", "1", "");
    run("d4_to_d6", "00A11000111000", "");
    en_i = 2'b00;
    run("d6_stop", "-", "");

    // D=0 then D=1 (load on a boundary): both clamp to 2, second ack one period later.
    load0(8'd0);
    run("d0_load", "-", "");
    en_i = 2'b01;
    run("d0_run", "A0", "");
    load0(8'd1);
    run("d1_load_at_boundary", "1", "");
    run("d1_run", "0A010", "");
    en_i = 2'b00;
    run("d1_stop", "-", "");

    // Double load collapses to one ack; both channels D=3 enabled together match.
    div_i = {8'd3, 8'd9};
    load_i = 2'b11;
    run("dual_load1", "-", "-");
    load0(8'd3);
    run("dual_load2", "-", "-");
    en_i = 2'b11;
    run("dual_d3", "A10110", "A10110");
    en_i = 2'b00;
    run("dual_stop", "-", "-");

    // D=8, en dropped in the second high cycle: full period then idle.
    load0(8'd8);
    run("d8_load", "-", "");
    en_i = 2'b01;
    run("d8_run", "A1", "");
    en_i = 2'b00;
    run("d8_drain", "110000", "");
    run("d8_idle", "-", "");

    // Re-enable before the boundary keeps running without a gap, then reset mid-high.
    en_i = 2'b01;
    run("d8_rerun", "11", "");
    en_i = 2'b00;
    run("d8_drop", "110", "");
    en_i = 2'b01;
    run("d8_reassert", "0001", "");
    run("d8_high", "1", "");
    rst = 1'b1;
    run("rst_mid_high", "-", "");
    rst = 1'b0;
    run("after_rst_div4", "1100", "");
    en_i = 2'b00;
    run("after_rst_stop", "-", "");

    // D=3 then D=7: one rise (tick) per period, none duplicated or lost.
    load0(8'd3);
    run("d3_load", "-", "");
    en_i = 2'b01;
    run("d3_run", "A101", "");
    load0(8'd7);
    run("d7_load", "1", "");
    run("d3_to_d7", "0A1110001111000", "");
    en_i = 2'b00;
    run("d7_stop", "-", "");

    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk_i);
    #1;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
